// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, ready/valid output with overrun flag.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [BaudW-1:0] BaudFull = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudHalf = BaudW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 done;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_q, parity_err_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign tick = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = StStart;
          baud_d  = BaudHalf;
          bit_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else if (!rx_sync_q) begin
          state_d = StData;
          baud_d  = BaudFull;
        end else begin
          state_d = StIdle;  // glitch: line back high at mid-bit
        end
      end
      StData: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          baud_d  = BaudFull;
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          par_d   = rx_sync_q;
          baud_d  = BaudFull;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (!tick) begin
          baud_d = baud_q - 1'b1;
        end else begin
          ferr_d = ferr_q | ~rx_sync_q;
          baud_d = BaudFull;
          if (bit_q == StopLast) begin
            bit_d   = '0;
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A completing word loads only if the output slot is empty or being drained this cycle.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d   = shift_q;
        rx_valid_d  = 1'b1;
        frame_err_d = ferr_d;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (^{shift_q, par_q}) ^ (PARITY_ODD != 0);
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core at default parameters (16 clk/bit, 8N1).
// Parity scenarios follow UART_RX_PARITY_EN when defined.
module tb_uart_rx_core;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  // Accepted words as {frame_err, parity_err, data}; counters only grow.
  logic [9:0] got_q[$];
  int ovr_cnt = 0;
  int vld_cycles = 0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) vld_cycles++;
    if (rx_valid && rx_ready) got_q.push_back({frame_err, parity_err, rx_data});
    if (overrun) ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`endif
    drive_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    int base = got_q.size();
    int v0 = vld_cycles;
    int o0 = ovr_cnt;
    logic [9:0] w;
    rx_ready = 1'b1;
    send_frame(8'hAA, 1'b1);
    tick(4);
    w = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size() - base); end
    checks++; if (w !== 10'h0AA) begin errors++; $display("FAIL single_word got %h exp 0aa", w); end
    checks++; if (vld_cycles - v0 != 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", vld_cycles - v0); end
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL single_ovr got %0d exp 0", ovr_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int base = got_q.size();
    int o0 = ovr_cnt;
    logic [9:0] w0, w1;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(4);
    w0 = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    w1 = (got_q.size() > base + 1) ? got_q[base+1] : 10'h3FF;
    checks++; if (got_q.size() - base != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size() - base); end
    checks++; if (w0 !== 10'h03C) begin errors++; $display("FAIL b2b_word0 got %h exp 03c", w0); end
    checks++; if (w1 !== 10'h03C) begin errors++; $display("FAIL b2b_word1 got %h exp 03c", w1); end
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL b2b_ovr got %0d exp 0", ovr_cnt - o0); end
  endtask

  task automatic test_overrun();
    int base = got_q.size();
    int o0 = ovr_cnt;
    logic [9:0] w;
    rx_ready = 1'b0;
    send_frame(8'h33, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(4);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got %b exp 1", rx_valid); end
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL ovr_held_data got %h exp 33", rx_data); end
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
    rx_ready = 1'b1;
    tick(4);
    w = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", got_q.size() - base); end
    checks++; if (w !== 10'h033) begin errors++; $display("FAIL ovr_word got %h exp 033", w); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained_valid got %b exp 0", rx_valid); end
  endtask

  task automatic test_glitch();
    int v0 = vld_cycles;
    logic saw_busy = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    for (int i = 0; i < Cpb / 2 + 3; i++) begin
      if (busy) saw_busy = 1'b1;
      tick(1);
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b exp 1", saw_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
    tick(Cpb);
    checks++; if (vld_cycles != v0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", vld_cycles - v0); end
  endtask

  task automatic test_frame_err();
    int base = got_q.size();
    logic [9:0] w0, w1;
    send_frame(8'h5A, 1'b0);
    tick(Cpb);
    send_frame(8'hAA, 1'b1);
    tick(4);
    w0 = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    w1 = (got_q.size() > base + 1) ? got_q[base+1] : 10'h3FF;
    checks++; if (w0 !== 10'h25A) begin errors++; $display("FAIL ferr_word got %h exp 25a", w0); end
    checks++; if (w1 !== 10'h0AA) begin errors++; $display("FAIL ferr_cleared got %h exp 0aa", w1); end
  endtask

  task automatic test_parity();
    int base = got_q.size();
    logic [9:0] w0, w1;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h01, 1'b1);
    par_flip = 1'b0;
    send_frame(8'h01, 1'b1);
    tick(4);
    w0 = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    w1 = (got_q.size() > base + 1) ? got_q[base+1] : 10'h3FF;
    checks++; if (w0 !== 10'h101) begin errors++; $display("FAIL parity_bad got %h exp 101", w0); end
    checks++; if (w1 !== 10'h001) begin errors++; $display("FAIL parity_good got %h exp 001", w1); end
`else
    send_frame(8'h01, 1'b1);
    send_frame(8'hFE, 1'b1);
    tick(4);
    w0 = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    w1 = (got_q.size() > base + 1) ? got_q[base+1] : 10'h3FF;
    checks++; if (w0 !== 10'h001) begin errors++; $display("FAIL noparity_word0 got %h exp 001", w0); end
    checks++; if (w1 !== 10'h0FE) begin errors++; $display("FAIL noparity_word1 got %h exp 0fe", w1); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [9:0] w;
    logic [12:0] outs;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    #1 outs = {rx_valid, frame_err, parity_err, overrun, busy, rx_data};
    checks++; if (outs !== 13'h0) begin errors++; $display("FAIL midrst_async_outs got %h exp 0", outs); end
    rx = 1'b1;
    tick(3);
    outs = {rx_valid, frame_err, parity_err, overrun, busy, rx_data};
    checks++; if (outs !== 13'h0) begin errors++; $display("FAIL midrst_held_outs got %h exp 0", outs); end
    rst_n = 1'b1;
    tick(4);
    base = got_q.size();
    send_frame(8'h33, 1'b1);
    tick(Cpb * 4);
    w = (got_q.size() > base) ? got_q[base] : 10'h3FF;
    checks++; if (got_q.size() - base != 1) begin errors++; $display("FAIL midrst_count got %0d exp 1", got_q.size() - base); end
    checks++; if (w !== 10'h033) begin errors++; $display("FAIL midrst_word got %h exp 033", w); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
